banked_sram_arb: RTL
====================

Name: banked_sram_arb

Overview:
- Parametrised banked single-clock RAM built from N identical single-port bank primitives (spram32k8 class, one access per bank per cycle).
- Two request ports: A (video scan-out, high priority) and B (CPU), with per-bank arbitration.
- Both ports are served in the same cycle when they target different banks.
- Same-bank conflicts are resolved by priority, with a starvation guard for port B. Successor to the fixed 2 x 32K x 8 VRAM.

Parameters:
- DATA_WIDTH, 8, word width; must match bank primitive.
- BANK_ADDR_WIDTH, 15, address bits inside one bank (bank depth = 2^BANK_ADDR_WIDTH).
- BANK_SEL_WIDTH, 1, bank-select bits; bank count = 2^BANK_SEL_WIDTH; range 0..3.
- STARVE_LIMIT, 4, consecutive conflict-denied cycles after which port B wins one conflict; range 1..15.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  synchronous active-low reset.
- a_req  in  1  port A access request, held until a_ack.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  BANK_SEL_WIDTH+BANK_ADDR_WIDTH  port A word address; MSBs select bank.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_ack  out  1  port A granted this cycle (combinational); access performed at this edge.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_WIDTH  port A read data, registered.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid, b_rdata: same as port A, for port B.

Behaviour:
- Address split: bank = addr[top BANK_SEL_WIDTH bits], offset = addr[BANK_ADDR_WIDTH-1:0]. With BANK_SEL_WIDTH=0 there is one bank and every simultaneous request conflicts.
- Grant rules, evaluated each cycle:
  - Only one port requesting: it is acked.
  - Both requesting, different banks: both acked.
  - Both requesting, same bank: A acked unless starve_cnt == STARVE_LIMIT, in which case B acked.
- a_ack and b_ack are forced 0 while reset_n=0.
- starve_cnt (4-bit):
  - Resets to 0.
  - Increments (saturating at STARVE_LIMIT) on each cycle where b_req is high and B is denied due to conflict.
  - Clears to 0 on any cycle with b_ack=1.
  - Holds when b_req=0.
- Each bank's address, data and write enable are muxed from the acked port. Bank write enable = ack & we & (bank matches). Write is committed at the ack edge.
- Read latency is fixed at 2 cycles:
  - Ack with we=0 at edge N: the bank samples at N.
  - A registered bank-select/port tag is captured at N.
  - Output register loads the selected bank output at edge N+1.
  - rvalid is high for exactly the cycle after edge N+1.
  - rdata holds its last value until the next read completes.
- Back-to-back reads on one port give one result per cycle, fully pipelined, in order.
- Writes produce no rvalid.
- A read acked on the cycle after a write to the same address on either port returns the new data.
- Same-cycle same-address access by both ports cannot occur, because same-bank requests are serialised.
- Reset values: a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, starve_cnt=0, pipeline tags cleared.
- Reset mid-operation: in-flight reads are discarded with no rvalid after reset. RAM contents are not cleared.
- Requester must hold req/we/addr/wdata stable until ack. Dropping req before ack is legal and cancels the request with no side effect.

Test Plan:
- Reset, then A writes 0x5A at 0x0010 and B writes 0xA5 at 0x8010 in the same cycle -> a_ack=b_ack=1 that cycle; subsequent reads return 0x5A and 0xA5 respectively.
- A reads 0x0010 acked at edge N -> a_rvalid=1 only in the cycle after edge N+1, a_rdata=0x5A; b_rvalid stays 0.
- A and B both continuously request bank 0 (A at 0x0001, B at 0x0002), STARVE_LIMIT=4:
  - B denied 4 cycles, acked on the 5th, starve_cnt then 0.
  - Pattern repeats with period 5; A is never starved indefinitely.
- A issues reads 0x0000..0x0003 on consecutive cycles after preloading 0x11..0x44 -> a_rvalid high 4 consecutive cycles with data 0x11,0x22,0x33,0x44 in order.
- B acks write 0x77 to 0x4000, then reads 0x4000 on the next cycle -> b_rdata=0x77.
- B read acked, reset_n driven 0 on the next edge for 1 cycle -> no b_rvalid; b_rdata=0; a_ack=b_ack=0 during reset; RAM data at 0x4000 still 0x77 afterwards.
- Rerun with BANK_SEL_WIDTH=2 and BANK_SEL_WIDTH=0 -> correct bank decode for each; with 0, every simultaneous request conflicts.

Source files
------------

// File: rtl/banked_sram_arb_if.sv
// Two-port request/response bundle for the banked SRAM arbiter.
// Port A is the high-priority video side, port B the CPU side.
interface banked_sram_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_ack;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_ack;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rvalid, b_rdata
  );
endinterface

// File: rtl/banked_sram_arb.sv
// Banked single-port RAM shared by two request ports with per-bank arbitration,
// A-priority on conflicts and a starvation guard that lets B through periodically.
module banked_sram_arb #(
  parameter int DATA_WIDTH      = 8,
  parameter int BANK_ADDR_WIDTH = 15,
  parameter int BANK_SEL_WIDTH  = 1,
  parameter int STARVE_LIMIT    = 4
) (
  input logic              clk,
  input logic              reset_n,
  banked_sram_arb_if.slave bus
);
  localparam int NBANKS = 1 << BANK_SEL_WIDTH;
  // Zero select bits still need a 1-bit tag so every vector stays legal.
  localparam int SEL_W  = (BANK_SEL_WIDTH > 0) ? BANK_SEL_WIDTH : 1;
  localparam int ADDR_W = BANK_SEL_WIDTH + BANK_ADDR_WIDTH;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef logic [SEL_W-1:0]           sel_t;
  typedef logic [BANK_ADDR_WIDTH-1:0] offs_t;
  typedef logic [DATA_WIDTH-1:0]      word_t;

  function automatic sel_t bank_of(input logic [ADDR_W-1:0] addr);
    if (BANK_SEL_WIDTH == 0) return '0;
    return sel_t'(addr >> BANK_ADDR_WIDTH);
  endfunction

  function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
    return (cnt >= LIMIT) ? LIMIT : cnt + 4'd1;
  endfunction

  sel_t       a_bank, b_bank;
  logic       same_bank, b_turn, a_ack, b_ack;
  logic [3:0] starve_cnt;

  always_comb begin
    a_bank    = bank_of(bus.a_addr);
    b_bank    = bank_of(bus.b_addr);
    same_bank = (a_bank == b_bank);
    b_turn    = (starve_cnt == LIMIT);
    a_ack     = reset_n && bus.a_req && !(bus.b_req && same_bank && b_turn);
    b_ack     = reset_n && bus.b_req && !(bus.a_req && same_bank && !b_turn);
  end

  assign bus.a_ack = a_ack;
  assign bus.b_ack = b_ack;

  // ---- stage p0: bank access at the ack edge, registered bank output ----
  word_t bank_q [1 << SEL_W];

  for (genvar k = 0; k < (1 << SEL_W); k++) begin : g_bank
    if (k < NBANKS) begin : g_mem
      word_t mem [1 << BANK_ADDR_WIDTH];
      word_t q;
      logic  sel_a, sel_b, en, we;
      offs_t offs;
      word_t wdata;

      always_comb begin
        sel_a = a_ack && (a_bank == sel_t'(k));
        sel_b = b_ack && (b_bank == sel_t'(k));
        en    = sel_a || sel_b;
        we    = sel_a ? bus.a_we : bus.b_we;
        offs  = sel_a ? bus.a_addr[BANK_ADDR_WIDTH-1:0] : bus.b_addr[BANK_ADDR_WIDTH-1:0];
        wdata = sel_a ? bus.a_wdata : bus.b_wdata;
      end

      always_ff @(posedge clk) begin
        if (en) begin
          if (we) mem[offs] <= wdata;
          else    q         <= mem[offs];
        end
      end

      assign bank_q[k] = q;
    end else begin : g_none
      assign bank_q[k] = '0;
    end
  end

  logic  a_vld_p0, b_vld_p0;
  sel_t  a_bank_p0, b_bank_p0;
  logic  a_vld_p1, b_vld_p1;
  word_t a_rdata_p1, b_rdata_p1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_vld_p0   <= 1'b0;
      b_vld_p0   <= 1'b0;
      a_bank_p0  <= '0;
      b_bank_p0  <= '0;
      a_vld_p1   <= 1'b0;
      b_vld_p1   <= 1'b0;
      a_rdata_p1 <= '0;
      b_rdata_p1 <= '0;
      starve_cnt <= '0;
    end else begin
      a_vld_p0  <= a_ack && !bus.a_we;
      b_vld_p0  <= b_ack && !bus.b_we;
      a_bank_p0 <= a_bank;
      b_bank_p0 <= b_bank;
      // ---- stage p1: steer the tagged bank output into the port register ----
      a_vld_p1  <= a_vld_p0;
      b_vld_p1  <= b_vld_p0;
      if (a_vld_p0) a_rdata_p1 <= bank_q[a_bank_p0];
      if (b_vld_p0) b_rdata_p1 <= bank_q[b_bank_p0];
      // With reset released, a requesting B that is not acked lost a conflict.
      if (b_ack)            starve_cnt <= '0;
      else if (bus.b_req)   starve_cnt <= starve_inc(starve_cnt);
    end
  end

  assign bus.a_rvalid = a_vld_p1;
  assign bus.a_rdata  = a_rdata_p1;
  assign bus.b_rvalid = b_vld_p1;
  assign bus.b_rdata  = b_rdata_p1;
endmodule
